// File: rtl/sreg_ctrl_pkg.sv
// Shared types and sizing for the pixel shift-register readout sequencer.
package sreg_ctrl_pkg;

   localparam int PIXEL_W      = 42;
   localparam int LANES        = 2;
   localparam int NPIX_W       = 8;
   localparam int SHIFTS       = PIXEL_W / LANES;
   localparam int SAMPLE_CNT_W = $clog2(SHIFTS);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      OUT,
      FINISH
   } state_e;

endpackage

// File: rtl/sreg_lane_deser.sv
// Sample counter plus lane deserialiser: each sample drops one bit per lane into
// its MSB-first position inside the pixel word.
module sreg_lane_deser
   import sreg_ctrl_pkg::*;
(
   input  logic                 sclk,
   input  logic                 rst_n,
   input  logic                 clear_i,
   input  logic                 sample_en_i,
   input  logic [LANES-1:0]     lane_i,
   output logic [PIXEL_W-1:0]   word_o,
   output logic                 last_sample_o,
   output logic                 next_last_o
);

   localparam logic [SAMPLE_CNT_W-1:0] CNT_LAST = SAMPLE_CNT_W'(SHIFTS - 1);
   localparam logic [SAMPLE_CNT_W-1:0] CNT_PEN  = SAMPLE_CNT_W'(SHIFTS - 2);

   logic [SAMPLE_CNT_W-1:0] cnt_q, cnt_d;
   logic [PIXEL_W-1:0]      word_q, word_d;

   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
      if (clear_i) begin
         cnt_d  = '0;
         word_d = '0;
      end else if (sample_en_i) begin
         // sample k lands on bit (SHIFTS-1-k) of every lane slice
         for (int l = 0; l < LANES; l++) begin
            for (int j = 0; j < SHIFTS; j++) begin
               if (cnt_q == SAMPLE_CNT_W'(SHIFTS - 1 - j)) begin
                  word_d[l*SHIFTS + j] = lane_i[l];
               end
            end
         end
         if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + SAMPLE_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         word_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

   assign word_o        = word_q;
   assign last_sample_o = (cnt_q == CNT_LAST);
   assign next_last_o   = (cnt_q == CNT_PEN);

endmodule

// File: rtl/sreg_readout_ctrl.sv
// Readout sequencer for the 42-bit pixel shift-register chain: load, shift out
// over two lanes, reassemble, and hand each word to the packetiser.
//
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD   | sreg_load pulse, sample counter cleared
//   SHIFT  | 21 samples of sreg_dout, shift pulse on the first 20
//   OUT    | pix_valid held until pix_ready
//   FINISH | one-cycle done pulse, still busy
module sreg_readout_ctrl
   import sreg_ctrl_pkg::*;
(
   input  logic                sclk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [NPIX_W-1:0]   n_pixels_i,
   output logic                sreg_load_o,
   output logic                sreg_shift_o,
   input  logic [LANES-1:0]    sreg_dout_i,
   output logic [PIXEL_W-1:0]  pix_data_o,
   output logic [NPIX_W-1:0]   pix_index_o,
   output logic                pix_valid_o,
   input  logic                pix_ready_i,
   output logic                busy_o,
   output logic                done_o
);

   state_e            state_q, state_d;
   logic [NPIX_W-1:0] npix_q, npix_d;
   logic [NPIX_W-1:0] idx_q, idx_d;
   logic              load_q, shift_q, valid_q, busy_q, done_q;
   logic              shift_d;
   logic              last_sample, next_last;

   sreg_lane_deser u_deser (
      .sclk          (sclk),
      .rst_n         (rst_n),
      .clear_i       (state_q == LOAD),
      .sample_en_i   (state_q == SHIFT),
      .lane_i        (sreg_dout_i),
      .word_o        (pix_data_o),
      .last_sample_o (last_sample),
      .next_last_o   (next_last)
   );

   always_comb begin
      state_d = state_q;
      npix_d  = npix_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (start_i && !abort_i) begin
               if (n_pixels_i != '0) begin
                  npix_d  = n_pixels_i;
                  idx_d   = '0;
                  state_d = LOAD;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         LOAD:  state_d = SHIFT;
         SHIFT: if (last_sample) state_d = OUT;
         OUT: begin
            if (pix_ready_i) begin
               idx_d   = idx_q + NPIX_W'(1);
               state_d = ((idx_q + NPIX_W'(1)) == npix_q) ? FINISH : LOAD;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // abort in FINISH falls through to IDLE, so it never doubles the done pulse
      if (abort_i && (state_q != IDLE) && (state_q != FINISH)) begin
         state_d = FINISH;
         idx_d   = idx_q;
      end
   end

   // the sample about to be taken next cycle must not be followed by a shift if it is the last
   assign shift_d = (state_d == SHIFT) && !((state_q == SHIFT) && next_last);

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         npix_q  <= '0;
         idx_q   <= '0;
         load_q  <= 1'b0;
         shift_q <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         npix_q  <= npix_d;
         idx_q   <= idx_d;
         load_q  <= (state_d == LOAD);
         shift_q <= shift_d;
         valid_q <= (state_d == OUT);
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == FINISH);
      end
   end

   assign sreg_load_o  = load_q;
   assign sreg_shift_o = shift_q;
   assign pix_index_o  = idx_q;
   assign pix_valid_o  = valid_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule
